// File: rtl/compact_queue_pkg.sv
// Shared helpers for the age-ordered compacting queue.
// Width helper keeps index fields at least one bit wide for tiny parameter choices.
package compact_queue_pkg;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/compact_queue_popcount.sv
// Exclusive prefix popcount: cnt[k] is the number of set bits in vec[k-1:0], k = 0..N.
// The caller sizes CW so that cnt[N] cannot wrap.
module prefix_popcount #(
  parameter int N  = 4,
  parameter int CW = $clog2(N + 1)
) (
  input  logic [N-1:0]  vec,
  output logic [CW-1:0] cnt [N+1]
);

  always_comb begin
    logic [CW-1:0] acc;
    acc    = '0;
    cnt[0] = '0;
    for (int k = 0; k < N; k++) begin
      acc        = acc + CW'(vec[k]);
      cnt[k + 1] = acc;
    end
  end

endmodule

// File: rtl/compact_queue.sv
// Age-ordered self-compacting queue: entry 0 is the oldest, any subset may retire per cycle,
// and up to Producers pushes append behind the survivors on the same falling edge.
module compact_queue
  import compact_queue_pkg::*;
#(
  parameter int  Size         = 16,
  parameter type T            = logic,
  parameter int  Producers    = 1,
  parameter bit  PopFreesSlot = 1'b1
) (
  input  logic                 clk_ni,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic [Producers-1:0] push_i,
  input  T                     data_i [Producers],
  output logic [Producers-1:0] accept_o,
  input  logic [Size-1:0]      pop_i,
  output logic [$clog2(Size):0] size_o,
  output logic [Size-1:0]      valid_o,
  output T                     data_o [Size],
  output logic                 empty_o,
  output logic                 full_o
);

  localparam int CW = $clog2(Size) + 1;
  localparam int W  = clog2_min1(Size);
  localparam int PW = $clog2(Producers + 1);

  typedef logic [CW-1:0] count_t;
  typedef logic [W-1:0]  slot_t;

  count_t          size_q;
  T                mem_q [Size];
  T                mem_n [Size];
  logic [Size-1:0] pop_eff;
  count_t          pcnt [Size+1];
  logic [PW-1:0]   rank [Producers+1];
  count_t          npop;
  count_t          free;
  count_t          base;
  count_t          nacc;

  always_comb begin
    for (int k = 0; k < Size; k++) begin
      valid_o[k] = (count_t'(k) < size_q);
    end
  end

  assign pop_eff = pop_i & valid_o;

  prefix_popcount #(.N(Size), .CW(CW)) u_pop_cnt (
    .vec (pop_eff),
    .cnt (pcnt)
  );

  prefix_popcount #(.N(Producers), .CW(PW)) u_push_rank (
    .vec (push_i),
    .cnt (rank)
  );

  assign npop = pcnt[Size];
  assign base = size_q - npop;

  always_comb begin
    free = count_t'(Size) - size_q + (PopFreesSlot ? npop : count_t'(0));
    for (int i = 0; i < Producers; i++) begin
      // Compare at 32 bits: rank can be wider than the size field when Producers > Size.
      accept_o[i] = push_i[i] && !flush_i && (32'(rank[i]) < 32'(free));
    end
    // Grants are a prefix of the requesters, so the grant count is min(requests, free).
    if (flush_i) begin
      nacc = '0;
    end else if (32'(rank[Producers]) < 32'(free)) begin
      nacc = count_t'(rank[Producers]);
    end else begin
      nacc = free;
    end
  end

  always_comb begin
    mem_n = mem_q;
    for (int k = 0; k < Size; k++) begin
      if (valid_o[k] && !pop_i[k]) begin
        mem_n[slot_t'(count_t'(k) - pcnt[k])] = mem_q[k];
      end
    end
    for (int i = 0; i < Producers; i++) begin
      if (accept_o[i]) begin
        mem_n[slot_t'(base + count_t'(rank[i]))] = data_i[i];
      end
    end
  end

  // Payload storage is deliberately left unreset; only occupancy defines validity.
  always_ff @(negedge clk_ni) begin
    if (rst_i) begin
      size_q <= '0;
    end else if (flush_i) begin
      size_q <= '0;
    end else begin
      size_q <= base + nacc;
      mem_q  <= mem_n;
    end
  end

  assign size_o  = size_q;
  assign data_o  = mem_q;
  assign empty_o = (size_q == '0);
  assign full_o  = (size_q == count_t'(Size));

endmodule
